// File: rtl/logic_analyzer_reader_if.sv
// Output stream of logic_analyzer_reader: one header word, then the captured words.
// A beat is o_valid & o_ready; o_last marks the final beat of a frame.
interface logic_analyzer_reader_if;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_ready;
  logic        o_last;

  modport master (output o_data, output o_valid, output o_last, input o_ready);
  modport slave  (input o_data, input o_valid, input o_last, output o_ready);
endinterface

// File: rtl/logic_analyzer_reader.sv
// Drains a finished logic_analyzer capture onto a valid/ready stream.
// Strobes are credit-limited so words returning from the BRAM always fit in the skid FIFO.
module logic_analyzer_reader #(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [15:0] HEADER_TAG   = 16'h1A5A
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    auto_restart,
  input  logic                    la_finished,
  input  logic [31:0]             la_read_size,
  input  logic [31:0]             la_data,
  output logic                    la_read_strobe,
  output logic                    la_restart,
  output logic                    busy,
  output logic                    aborted,
  logic_analyzer_reader_if.master stream
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {StIdle, StSettle, StHeader, StDrain, StWaitDone} state_e;

  state_e                  state_q, state_d;
  logic                    settle_q;
  logic [31:0]             size_q, issued_q, sent_q;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [CntW-1:0]         inflight_q, count_q;
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [31:0]             mem_q [FIFO_DEPTH];
  logic                    aborted_q, restart_q;

  logic        abort, strobe, push, pop, clear, credit;
  logic [31:0] out_data;
  logic        out_valid, out_last;

  assign push   = vld_q[READ_LATENCY-1];
  assign credit = (32'(inflight_q) + 32'(count_q)) < FIFO_DEPTH;
  // IDLE holds the datapath empty, so abort only needs to return there.
  assign clear  = abort || (state_q == StIdle);

  always_comb begin
    state_d   = state_q;
    abort     = 1'b0;
    strobe    = 1'b0;
    pop       = 1'b0;
    out_data  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && la_finished) state_d = StSettle;
      end
      StSettle: begin
        if (!enable) abort = 1'b1;
        else if (settle_q) state_d = StHeader;
      end
      StHeader: begin
        out_valid = 1'b1;
        out_data  = {HEADER_TAG, size_q[15:0]};
        out_last  = (size_q == 32'd0);
        if (!enable) abort = 1'b1;
        else if (stream.o_ready) state_d = (size_q == 32'd0) ? StWaitDone : StDrain;
      end
      StDrain: begin
        out_valid = (count_q != '0);
        out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
        out_last  = out_valid && (sent_q + 32'd1 == size_q);
        pop       = out_valid && stream.o_ready;
        // No new requests once enable drops, so nothing is left in flight after abort.
        strobe    = enable && (issued_q < size_q) && credit;
        if (!enable) abort = 1'b1;
        else if (pop && out_last) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (!enable || !la_finished) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = strobe;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      settle_q   <= 1'b0;
      size_q     <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      vld_q      <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      aborted_q  <= 1'b0;
      restart_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= (state_q == StSettle);
      aborted_q <= abort;
      restart_q <= auto_restart && (state_d == StWaitDone) && (state_q != StWaitDone);
      if (state_q == StIdle && state_d == StSettle) size_q <= la_read_size;
      if (clear) begin
        issued_q   <= '0;
        sent_q     <= '0;
        vld_q      <= '0;
        inflight_q <= '0;
        count_q    <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
      end else begin
        vld_q      <= vld_d;
        inflight_q <= inflight_q + CntW'(strobe) - CntW'(push);
        count_q    <= count_q + CntW'(push) - CntW'(pop);
        issued_q   <= issued_q + 32'(strobe);
        sent_q     <= sent_q + 32'(pop);
        if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= la_data;
  end

  assign la_read_strobe = strobe;
  assign la_restart     = restart_q;
  assign aborted        = aborted_q;
  assign busy           = (state_q != StIdle);
  assign stream.o_data  = out_data;
  assign stream.o_valid = out_valid;
  assign stream.o_last  = out_last;

endmodule

// File: tb/tb_logic_analyzer_reader.sv
// Bench for logic_analyzer_reader: a BRAM model with fixed read latency feeds the DUT and
// every stream beat is compared with the frame expected from the capture contents.
module tb_logic_analyzer_reader;
  localparam int unsigned L     = 2;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        auto_restart = 1'b0;
  logic        la_finished = 1'b0;
  logic [31:0] la_read_size = '0;
  logic [31:0] la_data;
  logic        la_read_strobe, la_restart, busy, aborted;

  always #5 clk = ~clk;

  logic_analyzer_reader_if stream ();

  logic_analyzer_reader #(
    .READ_LATENCY(L),
    .FIFO_DEPTH  (DEPTH),
    .HEADER_TAG  (16'h1A5A)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .auto_restart  (auto_restart),
    .la_finished   (la_finished),
    .la_read_size  (la_read_size),
    .la_data       (la_data),
    .la_read_strobe(la_read_strobe),
    .la_restart    (la_restart),
    .busy          (busy),
    .aborted       (aborted),
    .stream        (stream)
  );

  // Capture memory: word n of the frame is returned L cycles after the n-th strobe.
  logic [31:0]          tb_mem [16];
  logic [L-1:0][31:0]   pipe;
  int unsigned          addr = 0;
  always @(posedge clk) begin
    pipe <= {pipe[L-2:0], (la_read_strobe ? tb_mem[4'(addr)] : 32'hDEAD_BEEF)};
    if (!la_finished) addr <= 0;
    else if (la_read_strobe) addr <= addr + 1;
  end
  assign la_data = pipe[L-1];

  int unsigned cyc = 0, beat_cnt = 0, strobe_cnt = 0, restart_cnt = 0, abort_cnt = 0;
  int unsigned restart_cyc = 0;
  logic [31:0] beat_data [512];
  logic        beat_last [512];
  int unsigned beat_cyc  [512];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (stream.o_valid && stream.o_ready) begin
      beat_data[9'(beat_cnt)] <= stream.o_data;
      beat_last[9'(beat_cnt)] <= stream.o_last;
      beat_cyc[9'(beat_cnt)]  <= cyc;
      beat_cnt <= beat_cnt + 1;
    end
    if (la_read_strobe) strobe_cnt <= strobe_cnt + 1;
    if (la_restart) begin
      restart_cnt <= restart_cnt + 1;
      restart_cyc <= cyc;
    end
    if (aborted) abort_cnt <= abort_cnt + 1;
  end

  int unsigned tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_mem(input logic fixed);
    for (int i = 0; i < 16; i++)
      tb_mem[i] = fixed ? 32'(32'hA0 + i) : {4'h0, 12'($urandom), 16'($urandom)};
  endtask

  // mode 0: ready always 1, 1: header stalled then ready toggling, 2: random ready
  task automatic run_frame(input int unsigned size, input int unsigned mode, input logic ar,
                           input logic fixed);
    int unsigned b0, s0, r0, t, first_valid, hdr_bad, out_max, dbeats, outst;
    logic [31:0] hdr, exp;
    hdr = {16'h1A5A, size[15:0]};
    b0 = beat_cnt; s0 = strobe_cnt; r0 = restart_cnt;
    first_valid = 0; hdr_bad = 0; out_max = 0;
    fill_mem(fixed);
    @(negedge clk);
    auto_restart = ar; la_read_size = size; enable = 1'b1; la_finished = 1'b1;
    stream.o_ready = (mode == 0);
    t = 0;
    while (beat_cnt < b0 + size + 1 && t < 2000) begin
      @(negedge clk);
      t++;
      if (first_valid == 0 && stream.o_valid) first_valid = t;
      if (beat_cnt == b0 && stream.o_valid && stream.o_data !== hdr) hdr_bad++;
      dbeats = (beat_cnt > b0) ? beat_cnt - b0 - 1 : 0;
      outst = strobe_cnt - s0 - dbeats;
      if (outst > out_max) out_max = outst;
      case (mode)
        0:       stream.o_ready = 1'b1;
        1:       stream.o_ready = t[0] && (t > 5);
        default: stream.o_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
    stream.o_ready = 1'b0;
    check("beat_count", beat_cnt - b0, size + 1);
    for (int i = 0; i <= int'(size); i++) begin
      if (i == 0) exp = hdr;
      else exp = tb_mem[4'(i - 1)];
      check("beat_data", beat_data[9'(b0 + i)], exp);
      check("beat_last", 32'(beat_last[9'(b0 + i)]), 32'(i == int'(size)));
    end
    check("strobes", strobe_cnt - s0, size);
    check("hdr_latency", first_valid, 3);
    check("hdr_stable", hdr_bad, 0);
    check("credit_limit", 32'(out_max <= DEPTH), 1);
    if (mode == 0 && size > 0) begin
      check("data_latency", beat_cyc[9'(b0 + 1)] - beat_cyc[9'(b0)], L + 2);
      check("throughput", beat_cyc[9'(b0 + size)] - beat_cyc[9'(b0 + 1)], size - 1);
    end
    repeat (3) @(negedge clk);
    check("restart_count", restart_cnt - r0, ar ? 1 : 0);
    if (ar) check("restart_cycle", restart_cyc, beat_cyc[9'(b0 + size)] + 1);
    check("wait_busy", 32'(busy), 1);
    la_finished = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned b0, s1, a0, t;
    stream.o_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(stream.o_valid), 0);
    check("rst_data", stream.o_data, 0);
    check("rst_last", 32'(stream.o_last), 0);
    check("rst_strobe", 32'(la_read_strobe), 0);
    check("rst_restart", 32'(la_restart), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_aborted", 32'(aborted), 0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(4, 0, 1'b0, 1'b1);
    run_frame(8, 1, 1'b0, 1'b0);
    run_frame(0, 0, 1'b0, 1'b0);
    run_frame(2, 0, 1'b1, 1'b0);

    // Abort after three data beats of an eight-word frame.
    b0 = beat_cnt; a0 = abort_cnt;
    fill_mem(1'b0);
    @(negedge clk);
    auto_restart = 1'b0; la_read_size = 8; enable = 1'b1; la_finished = 1'b1;
    stream.o_ready = 1'b1;
    t = 0;
    while (beat_cnt < b0 + 4 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("abort_wait", beat_cnt - b0, 4);
    check("abort_data", beat_data[9'(b0 + 1)], tb_mem[0]);
    enable = 1'b0; stream.o_ready = 1'b0;
    s1 = strobe_cnt;
    @(negedge clk);
    check("abort_pulse", 32'(aborted), 1);
    check("abort_valid", 32'(stream.o_valid), 0);
    check("abort_busy", 32'(busy), 0);
    @(negedge clk);
    check("abort_pulse_end", 32'(aborted), 0);
    repeat (4) @(negedge clk);
    check("abort_no_strobes", strobe_cnt, s1);
    check("abort_count", abort_cnt - a0, 1);
    check("abort_no_beats", beat_cnt - b0, 4);
    la_finished = 1'b0;
    @(negedge clk);
    enable = 1'b1;

    // Asynchronous reset in the middle of a drain.
    b0 = beat_cnt;
    fill_mem(1'b0);
    @(negedge clk);
    la_read_size = 8; la_finished = 1'b1; stream.o_ready = 1'b1;
    t = 0;
    while (beat_cnt < b0 + 3 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rst_mid_wait", beat_cnt - b0, 3);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(stream.o_valid), 0);
    check("rst_mid_data", stream.o_data, 0);
    check("rst_mid_last", 32'(stream.o_last), 0);
    check("rst_mid_strobe", 32'(la_read_strobe), 0);
    check("rst_mid_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0; la_finished = 1'b0; stream.o_ready = 1'b0;
    @(negedge clk);
    run_frame(4, 0, 1'b0, 1'b0);

    for (int n = 0; n < 6; n++)
      run_frame($urandom_range(1, 12), 2, 1'($urandom_range(0, 1)), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
